// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end for the 16-bit pipelined CPU. It owns the fetch
// PC and issues sequential requests to instruction memory over a req/ack
// handshake that tolerates any response latency. Up to DEPTH fetched
// {pc, instruction} pairs are buffered and handed to IF/ID through a
// valid/ready interface. A branch/jump redirect flushes the queue. A memory
// response that is already in flight is still waited for, and then discarded.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_rst_n        synchronous active-low reset
//   o_mem_req      registered fetch request, held until i_mem_ack
//   o_mem_addr     registered fetch address, stable while o_mem_req is high
//   i_mem_ack      memory response strobe, only looked at while requesting
//   i_mem_rdata    instruction word, valid in the i_mem_ack cycle
//   i_redirect     one-cycle flush/restart pulse from branch resolution
//   i_redirect_pc  restart address, valid with i_redirect
//   o_out_valid    head entry available (forced low in a redirect cycle)
//   i_out_ready    consumer accepts the head entry
//   o_out_instr    head instruction
//   o_out_pc       address of the head instruction
//   o_count        current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    output logic                     o_mem_req,
    output logic [ADDR_W-1:0]        o_mem_addr,
    input  logic                     i_mem_ack,
    input  logic [DATA_W-1:0]        i_mem_rdata,
    input  logic                     i_redirect,
    input  logic [ADDR_W-1:0]        i_redirect_pc,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [DATA_W-1:0]        o_out_instr,
    output logic [ADDR_W-1:0]        o_out_pc,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // S_DROP: a redirect arrived while a request was outstanding; wait for
    // its ack so the stale response can be thrown away.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t              r_state;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   r_target;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_instr [DEPTH];
    logic [ADDR_W-1:0]   r_pc    [DEPTH];

    logic                w_pop;
    logic                w_push;
    logic [CNT_W:0]      w_cnt_ext;
    logic                w_room_idle;
    logic                w_room_wait;

    assign o_out_valid = (r_count != '0) && !i_redirect;
    assign w_pop       = o_out_valid && i_out_ready;
    // An ack coinciding with a redirect belongs to the squashed path.
    assign w_push      = (r_state == S_WAIT) && i_mem_ack && !i_redirect;

    // Room checks account for this cycle's pop (and, while waiting, for the
    // entry the current ack is about to write) so a request is only issued
    // when its response is guaranteed a free slot.
    assign w_cnt_ext   = {1'b0, r_count};
    assign w_room_idle = (w_cnt_ext - (CNT_W+1)'(w_pop)) < (CNT_W+1)'(DEPTH);
    assign w_room_wait = (w_cnt_ext + (CNT_W+1)'(1) - (CNT_W+1)'(w_pop))
                         < (CNT_W+1)'(DEPTH);

    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_out_instr = r_instr[r_rd_ptr];
    assign o_out_pc    = r_pc[r_rd_ptr];
    assign o_count     = r_count;

    // Queue storage: data only, no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= i_mem_rdata;
            r_pc[r_wr_ptr]    <= r_mem_addr;
        end
    end

    // Queue bookkeeping
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Fetch state machine with registered request outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_target   <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_redirect) begin
                        r_fetch_pc <= i_redirect_pc;
                    end else if (w_room_idle) begin
                        r_state    <= S_WAIT;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                S_WAIT: begin
                    if (i_mem_ack) begin
                        if (i_redirect) begin
                            r_fetch_pc <= i_redirect_pc;
                            r_mem_req  <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                            if (w_room_wait) begin
                                // back-to-back issue of the next address
                                r_mem_addr <= r_fetch_pc + ADDR_W'(1);
                            end else begin
                                r_mem_req <= 1'b0;
                                r_state   <= S_IDLE;
                            end
                        end
                    end else if (i_redirect) begin
                        // request stays up; its response will be dropped
                        r_target <= i_redirect_pc;
                        r_state  <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (i_mem_ack) begin
                        r_fetch_pc <= i_redirect ? i_redirect_pc : r_target;
                        r_mem_req  <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (i_redirect) begin
                        r_target <= i_redirect_pc;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue. A behavioural instruction memory answers
// each request after ack_lat waiting cycles with a data word derived from the
// address. A small scoreboard holds the next expected fetch address: it
// advances by one on every accepted output and jumps to the target of every
// redirect.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 16;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'h0010;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  redirect;
    logic [ADDR_W-1:0]     redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_instr;
    logic [ADDR_W-1:0]     out_pc;
    logic [$clog2(DEPTH):0] count;

    int          vectors     = 0;
    int          miscompares = 0;
    int          ack_lat     = 0;
    int          wait_cnt    = 0;
    int          ack_cnt     = 0;
    int          pop_cnt     = 0;
    logic [15:0] exp_pc      = RST_PC;

    fetch_queue #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RST_PC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_instr  (out_instr),
        .o_out_pc     (out_pc),
        .o_count      (count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] instr_of(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the memory response for the current cycle and let it settle.
    task automatic pre();
        mem_ack   = mem_req && (wait_cnt >= ack_lat);
        mem_rdata = instr_of(mem_addr);
        #1;
    endtask

    // Score this cycle's transfer, then advance one clock.
    task automatic post();
        if (rst_n) begin
            if (out_valid && out_ready) begin
                chk("pop_pc", out_pc, exp_pc);
                chk("pop_instr", out_instr, instr_of(exp_pc));
                $display("pop pc=%04h instr=%04h count=%0d", out_pc, out_instr, count);
                exp_pc++;
                pop_cnt++;
            end
            if (redirect) begin
                exp_pc = redirect_pc;
            end
            if (mem_req && mem_ack) begin
                ack_cnt++;
                wait_cnt = 0;
            end else if (mem_req) begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        @(posedge clk);
        #1;
        chk("count_bound", 32'(count <= DEPTH), 1);
    endtask

    task automatic tick();
        pre();
        post();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        exp_pc   = RST_PC;
        wait_cnt = 0;
        rst_n    = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;

        // ---- reset state, then zero-wait streaming ----
        ack_lat = 0;
        do_reset();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_mem_addr", mem_addr, 16'h0010);
        tick();
        chk("zw_first_req", mem_req, 1);
        chk("zw_first_addr", mem_addr, 16'h0010);
        chk("zw_first_valid", out_valid, 0);
        tick();
        chk("zw_head_valid", out_valid, 1);
        chk("zw_head_pc", out_pc, 16'h0010);
        chk("zw_head_count", count, 1);
        pop_cnt = 0;
        repeat (8) begin
            tick();
            chk("zw_count", count, 1);
        end
        chk("zw_pops", pop_cnt, 8);

        // ---- backpressure, 1-cycle ack latency ----
        out_ready = 1'b0;
        ack_lat   = 1;
        do_reset();
        ack_cnt = 0;
        repeat (20) tick();
        chk("bp_acks", ack_cnt, 4);
        chk("bp_req_low", mem_req, 0);
        chk("bp_full", count, 4);
        chk("bp_head_pc", out_pc, 16'h0010);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_pop_count", count, 3);
        chk("bp_reissue", mem_req, 1);
        chk("bp_reissue_addr", mem_addr, 16'h0014);
        tick();
        tick();
        chk("bp_refill", count, 4);
        chk("bp_refill_req", mem_req, 0);
        chk("bp_refill_acks", ack_cnt, 5);

        // ---- redirect while waiting on a slow response ----
        ack_lat   = 3;
        out_ready = 1'b1;
        tick();
        chk("rw_issue_addr", mem_addr, 16'h0015);
        chk("rw_issue_count", count, 3);
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        pre();
        chk("rw_valid_in_redirect", out_valid, 0);
        post();
        redirect = 1'b0;
        chk("rw_flush_count", count, 0);
        chk("rw_flush_valid", out_valid, 0);
        chk("rw_req_held", mem_req, 1);
        chk("rw_addr_held", mem_addr, 16'h0015);
        repeat (3) tick();
        chk("rw_drop_req", mem_req, 0);
        chk("rw_drop_count", count, 0);
        tick();
        chk("rw_new_req", mem_req, 1);
        chk("rw_new_addr", mem_addr, 16'h0200);
        repeat (4) tick();
        chk("rw_first_valid", out_valid, 1);
        chk("rw_first_pc", out_pc, 16'h0200);
        chk("rw_first_instr", out_instr, instr_of(16'h0200));

        // ---- redirect coinciding with an ack ----
        ack_lat = 0;
        repeat (3) tick();
        chk("ra_pre_count", count, 1);
        chk("ra_pre_req", mem_req, 1);
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        pre();
        chk("ra_valid_in_redirect", out_valid, 0);
        post();
        redirect = 1'b0;
        chk("ra_count", count, 0);
        chk("ra_req_low", mem_req, 0);
        tick();
        chk("ra_new_req", mem_req, 1);
        chk("ra_new_addr", mem_addr, 16'h0300);
        tick();
        chk("ra_first_pc", out_pc, 16'h0300);

        // ---- address wrap ----
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        tick();
        chk("wr_addr", mem_addr, 16'hFFFE);
        tick();
        chk("wr_pc0", out_pc, 16'hFFFE);
        tick();
        chk("wr_pc1", out_pc, 16'hFFFF);
        tick();
        chk("wr_pc2", out_pc, 16'h0000);
        tick();
        chk("wr_pc3", out_pc, 16'h0001);

        // ---- fill/drain rounds with random ready, latency and redirects ----
        pop_cnt = 0;
        for (int blk = 0; blk < 6; blk++) begin
            out_ready = 1'b0;
            ack_lat   = $urandom_range(0, 2);
            repeat (20) tick();
            chk("rnd_fill_count", count, DEPTH);
            chk("rnd_fill_req", mem_req, 0);
            for (int n = 0; n < 30; n++) begin
                out_ready = 1'($urandom_range(0, 1));
                ack_lat   = $urandom_range(0, 2);
                if ($urandom_range(0, 15) == 0) begin
                    redirect    = 1'b1;
                    redirect_pc = 16'($urandom);
                end
                tick();
                redirect = 1'b0;
            end
        end
        chk("rnd_pops_min", 32'(pop_cnt >= 3 * DEPTH), 1);

        // ---- reset in the middle of a fetch with two entries queued ----
        out_ready = 1'b0;
        ack_lat   = 1;
        do_reset();
        repeat (5) tick();
        chk("mr_pre_count", count, 2);
        chk("mr_pre_req", mem_req, 1);
        rst_n = 1'b0;
        tick();
        chk("mr_req", mem_req, 0);
        chk("mr_count", count, 0);
        chk("mr_valid", out_valid, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        ack_lat   = 0;
        exp_pc    = RST_PC;
        wait_cnt  = 0;
        tick();
        chk("mr_refetch_req", mem_req, 1);
        chk("mr_refetch_addr", mem_addr, 16'h0010);
        tick();
        chk("mr_first_pc", out_pc, 16'h0010);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
